// File: rtl/task_dispatch_scheduler.sv
// task_dispatch_scheduler
//   Buffers task instructions posted by the RPi command decoder in a FIFO and
//   hands them to task_manager one at a time. Each dispatched task is checked
//   for a valid opcode and then launched with a single-cycle execute pulse.
//   The block tracks the task until task_manager reports idle again.
//
//   Optional build macro: TASK_SCHED_COUNTERS_EN
//     defined   -> tasks_done / tasks_rejected are live 16-bit wrapping counters
//     undefined -> both outputs are tied to 16'h0 and no counter flops exist
//
//   FSM states:
//     state        | meaning
//     -------------+-------------------------------------------------------
//     S_IDLE       | waiting for a queued entry and an idle task_manager
//     S_CHECK      | tm_inst just updated; give tm_inst_valid a cycle to settle
//     S_LAUNCH     | tm_execute high for exactly this cycle
//     S_WAIT_START | waiting for tm_idle to fall, bounded by START_TIMEOUT
//     S_WAIT_DONE  | task running; waiting for tm_idle to return high
module task_dispatch_scheduler #(
  parameter int DEPTH         = 8,   // power of two, >= 2
  parameter int INST_W        = 80,
  parameter int START_TIMEOUT = 16   // >= 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INST_W-1:0]      rpi_inst,
  input  logic                   rpi_push,
  input  logic                   flush,
  output logic                   queue_full,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow,
  output logic [INST_W-1:0]      tm_inst,
  output logic                   tm_execute,
  input  logic                   tm_inst_valid,
  input  logic                   tm_idle,
  output logic                   busy,
  output logic [15:0]            tasks_done,
  output logic [15:0]            tasks_rejected
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop;
  state_t            state;
  logic [TMR_W-1:0]  start_tmr;

  // Full is the registered flag, so a push while full is dropped even if the
  // FSM pops in the same cycle. Flush wins over both push and pop.
  assign push_ok = rpi_push && !queue_full && !flush;
  assign pop     = (state == S_IDLE) && (count != '0) && tm_idle && !flush;

  assign queue_count = count;
  assign busy        = (state != S_IDLE);

  // Next occupancy from accepted push and pop.
  always_comb begin
    count_next = count;
    if (push_ok && !pop)
      count_next = count + 1'b1;
    else if (!push_ok && pop)
      count_next = count - 1'b1;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= rpi_inst;
  end

  // Pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      queue_full <= 1'b0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      queue_full <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      queue_full <= (count_next == CNT_W'(DEPTH));
      if (rpi_push && queue_full)
        overflow <= 1'b1;
    end
  end

  // Dispatch FSM with registered tm_inst / tm_execute. The start timer is a
  // down-counter loaded in S_LAUNCH; reaching zero while task_manager is still
  // idle means the opcode was accepted but no engine picked it up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tm_inst    <= '0;
      tm_execute <= 1'b0;
      start_tmr  <= '0;
    end else begin
      tm_execute <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tm_inst <= mem[rd_ptr];
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (tm_inst_valid) begin
            tm_execute <= 1'b1;
            state      <= S_LAUNCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          start_tmr <= TMR_W'(START_TIMEOUT - 1);
          state     <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!tm_idle)
            state <= S_WAIT_DONE;
          else if (start_tmr == '0)
            state <= S_IDLE;
          else
            start_tmr <= start_tmr - 1'b1;
        end
        S_WAIT_DONE: begin
          if (tm_idle)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TASK_SCHED_COUNTERS_EN
  logic done_evt;
  logic rej_evt;

  assign done_evt = (state == S_WAIT_DONE) && tm_idle;
  assign rej_evt  = ((state == S_CHECK) && !tm_inst_valid) ||
                    ((state == S_WAIT_START) && tm_idle && (start_tmr == '0));

  // Completion and rejection counters; both wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tasks_done     <= 16'h0;
      tasks_rejected <= 16'h0;
    end else begin
      if (done_evt)
        tasks_done <= tasks_done + 16'd1;
      if (rej_evt)
        tasks_rejected <= tasks_rejected + 16'd1;
    end
  end
`else
  assign tasks_done     = 16'h0;
  assign tasks_rejected = 16'h0;
`endif

endmodule

// File: tb/tb_task_dispatch_scheduler.sv
// Directed bench for task_dispatch_scheduler: a cycle-by-cycle vector table
// for dispatch, reject, timeout and FIFO boundaries, followed by hand-written
// flush-during-task and asynchronous-reset sequences.
module tb_task_dispatch_scheduler;

  localparam int DEPTH  = 8;
  localparam int INST_W = 80;
  localparam int CW     = $clog2(DEPTH) + 1;

`ifdef TASK_SCHED_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [INST_W-1:0] rpi_inst = '0;
  logic              rpi_push = 1'b0;
  logic              flush = 1'b0;
  logic              queue_full;
  logic [CW-1:0]     queue_count;
  logic              overflow;
  logic [INST_W-1:0] tm_inst;
  logic              tm_execute;
  logic              tm_inst_valid;
  logic              tm_idle = 1'b1;
  logic              busy;
  logic [15:0]       tasks_done;
  logic [15:0]       tasks_rejected;

  int total = 0;
  int bad = 0;
  int exec_pulses = 0;

  localparam logic [79:0] Z  = 80'h0;
  localparam logic [79:0] IA = 80'hFF_000000_000100_000200;
  localparam logic [79:0] IB = 80'h10_000000_000000_000055;
  localparam logic [79:0] IC = 80'hFE_000000_000000_0000AA;

  task_dispatch_scheduler #(.DEPTH(DEPTH), .INST_W(INST_W), .START_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .rpi_inst(rpi_inst), .rpi_push(rpi_push),
    .flush(flush), .queue_full(queue_full), .queue_count(queue_count),
    .overflow(overflow), .tm_inst(tm_inst), .tm_execute(tm_execute),
    .tm_inst_valid(tm_inst_valid), .tm_idle(tm_idle), .busy(busy),
    .tasks_done(tasks_done), .tasks_rejected(tasks_rejected)
  );

  always #5 clk = ~clk;

  // task_manager opcode decode model: FF and FE are valid opcodes.
  assign tm_inst_valid = (tm_inst[79:72] == 8'hFF) || (tm_inst[79:72] == 8'hFE);

  // Count launch pulses, sampled away from the active edge.
  always @(negedge clk) if (tm_execute === 1'b1) exec_pulses++;

  typedef struct {
    logic        push;
    logic        flsh;
    logic        idle;
    logic [79:0] inst;
    int          rep;
    logic [79:0] e_inst;
    logic        e_exec;
    logic        e_busy;
    int          e_cnt;
    logic        e_full;
    logic        e_ovf;
    int          e_done;
    int          e_rej;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic p, input logic f, input logic id,
                               input logic [79:0] in, input int rp,
                               input logic [79:0] ei, input logic ee, input logic eb,
                               input int ec, input logic ef, input logic eo,
                               input int ed, input int er);
    vec_t v;
    v.push = p; v.flsh = f; v.idle = id; v.inst = in; v.rep = rp;
    v.e_inst = ei; v.e_exec = ee; v.e_busy = eb; v.e_cnt = ec;
    v.e_full = ef; v.e_ovf = eo; v.e_done = ed; v.e_rej = er;
    vecs.push_back(v);
  endfunction

  function automatic logic [79:0] ecnt(input int v);
    return CNT_EN ? 80'(v) : 80'h0;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string pfx, input logic [79:0] ei, input logic ee,
                         input logic eb, input int ec, input logic ef, input logic eo,
                         input int ed, input int er);
    chk({pfx, " tm_inst"}, tm_inst, ei);
    chk({pfx, " tm_execute"}, 80'(tm_execute), 80'(ee));
    chk({pfx, " busy"}, 80'(busy), 80'(eb));
    chk({pfx, " queue_count"}, 80'(queue_count), 80'(ec));
    chk({pfx, " queue_full"}, 80'(queue_full), 80'(ef));
    chk({pfx, " overflow"}, 80'(overflow), 80'(eo));
    chk({pfx, " tasks_done"}, 80'(tasks_done), ecnt(ed));
    chk({pfx, " tasks_rejected"}, 80'(tasks_rejected), ecnt(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // Dispatch of a valid task that runs for 50 cycles.
    addv(1,0,1,IA,1,  Z ,0,0,1,0,0,0,0);
    addv(0,0,1,Z ,1,  IA,0,1,0,0,0,0,0);
    addv(0,0,1,Z ,1,  IA,1,1,0,0,0,0,0);
    addv(0,0,1,Z ,1,  IA,0,1,0,0,0,0,0);
    addv(0,0,0,Z ,1,  IA,0,1,0,0,0,0,0);
    addv(0,0,0,Z ,49, IA,0,1,0,0,0,0,0);
    addv(0,0,1,Z ,1,  IA,0,0,0,0,0,1,0);
    // Invalid opcode: rejected in S_CHECK, never launched.
    addv(1,0,1,IB,1,  IA,0,0,1,0,0,1,0);
    addv(0,0,1,Z ,1,  IB,0,1,0,0,0,1,0);
    addv(0,0,1,Z ,1,  IB,0,0,0,0,0,1,1);
    // Valid opcode with no engine: start timeout after 16 cycles in S_WAIT_START.
    addv(1,0,1,IC,1,  IB,0,0,1,0,0,1,1);
    addv(0,0,1,Z ,1,  IC,0,1,0,0,0,1,1);
    addv(0,0,1,Z ,1,  IC,1,1,0,0,0,1,1);
    addv(0,0,1,Z ,1,  IC,0,1,0,0,0,1,1);
    addv(0,0,1,Z ,15, IC,0,1,0,0,0,1,1);
    addv(0,0,1,Z ,1,  IC,0,0,0,0,0,1,2);
    // Fill to full with task_manager busy, overflow on the 9th push, then flush.
    for (int i = 0; i < 8; i++)
      addv(1,0,0,{8'hFF, 72'(i)},1, IC,0,0,i+1,(i == 7),0,1,2);
    addv(1,0,0,{8'hFF, 72'(8)},1, IC,0,0,8,1,1,1,2);
    addv(0,1,0,Z ,1,  IC,0,0,0,0,0,1,2);
    addv(1,1,0,IA,1,  IC,0,0,0,0,0,1,2);
    // Flush beats a dispatch that would otherwise happen.
    addv(1,0,0,IA,1,  IC,0,0,1,0,0,1,2);
    addv(0,1,1,Z ,1,  IC,0,0,0,0,0,1,2);
    // Push and pop in the same cycle keep count, then second entry is rejected.
    addv(1,0,0,IA,1,  IC,0,0,1,0,0,1,2);
    addv(1,0,1,IB,1,  IA,0,1,1,0,0,1,2);
    addv(0,0,1,Z ,1,  IA,1,1,1,0,0,1,2);
    addv(0,0,1,Z ,1,  IA,0,1,1,0,0,1,2);
    addv(0,0,0,Z ,1,  IA,0,1,1,0,0,1,2);
    addv(0,0,1,Z ,1,  IA,0,0,1,0,0,2,2);
    addv(0,0,1,Z ,1,  IB,0,1,0,0,0,2,2);
    addv(0,0,1,Z ,1,  IB,0,0,0,0,0,2,3);

    // Reset state.
    repeat (3) tick();
    chk_all("reset", Z, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk_all("post_reset", Z, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rpi_push = vecs[i].push;
      flush    = vecs[i].flsh;
      tm_idle  = vecs[i].idle;
      rpi_inst = vecs[i].inst;
      repeat (vecs[i].rep) tick();
      chk_all($sformatf("v%0d", i), vecs[i].e_inst, vecs[i].e_exec, vecs[i].e_busy,
              vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_done, vecs[i].e_rej);
    end
    rpi_push = 1'b0; flush = 1'b0; tm_idle = 1'b1;

    // Flush during S_WAIT_DONE with 3 queued: task completes, nothing else dispatched.
    p0 = exec_pulses;
    rpi_push = 1'b1; rpi_inst = IA; tick();
    rpi_push = 1'b0; tick();
    tick();
    tick();
    tm_idle = 1'b0; tick();
    rpi_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rpi_inst = {8'hFF, 72'(i + 16)};
      tick();
    end
    rpi_push = 1'b0;
    chk("flush_wd count3", 80'(queue_count), 80'(3));
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_wd count0", 80'(queue_count), 80'(0));
    chk("flush_wd busy", 80'(busy), 80'(1));
    tm_idle = 1'b1; tick();
    chk("flush_wd done", 80'(tasks_done), ecnt(3));
    chk("flush_wd idle", 80'(busy), 80'(0));
    repeat (5) tick();
    chk("flush_wd no_redispatch busy", 80'(busy), 80'(0));
    chk("flush_wd pulses", 80'(exec_pulses - p0), 80'(1));
    chk("flush_wd tm_inst", tm_inst, IA);
    chk("flush_wd count_end", 80'(queue_count), 80'(0));

    // Asynchronous reset in S_WAIT_DONE with a full, overflowed queue.
    rpi_push = 1'b1; rpi_inst = IA; tick();
    rpi_push = 1'b0; tick();
    tick();
    tick();
    tm_idle = 1'b0; tick();
    rpi_push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rpi_inst = {8'hFF, 72'(i + 32)};
      tick();
    end
    rpi_push = 1'b0;
    chk_all("pre_rst", IA, 0, 1, 8, 1, 1, 3, 3);
    p0 = exec_pulses;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", Z, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tm_idle = 1'b1;
    repeat (4) tick();
    chk_all("after_rst", Z, 0, 0, 0, 0, 0, 0, 0);
    chk("after_rst pulses", 80'(exec_pulses - p0), 80'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/task_dispatch_scheduler.md
Name: task_dispatch_scheduler

Overview:
- Queues 80-bit task instructions from the RPi interface in a FIFO.
- Dispatches queued tasks one at a time to task_manager by driving RPi_inst and a single-cycle execute_task.
- Tracks each task from launch to completion. Rejects invalid instructions and recovers when a task never starts.
- Sits between the RPi command decoder and task_manager, so the RPi can post work without polling idle.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- INST_W, 80, instruction width; must match the task_manager RPi_inst width.
- START_TIMEOUT, 16, cycles to wait for tm_idle to fall after launch; minimum 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rpi_inst  in  INST_W  instruction to enqueue.
- rpi_push  in  1  enqueue strobe; rpi_inst is sampled on the same edge.
- flush  in  1  discard all queued (not yet dispatched) entries; clears overflow.
- queue_full  out  1  count == DEPTH.
- queue_count  out  $clog2(DEPTH)+1  current number of entries.
- overflow  out  1  sticky: a push was attempted while full.
- tm_inst  out  INST_W  registered instruction driven to task_manager RPi_inst.
- tm_execute  out  1  one-cycle launch pulse to task_manager execute_task.
- tm_inst_valid  in  1  task_manager inst_valid.
- tm_idle  in  1  task_manager idle.
- busy  out  1  state != S_IDLE.
- tasks_done  out  16  completed-task counter; wraps.
- tasks_rejected  out  16  invalid or never-started task counter; wraps.

Behaviour:
- Reset values: tm_inst=0 (opcode 0, so inst_valid is low), tm_execute=0, busy=0, overflow=0, queue_count=0, queue_full=0, both counters=0, state=S_IDLE, FIFO pointers=0.
- Reset asserted mid-task: the FIFO and in-flight tracking are lost; no pulse is issued.
- FIFO push/pop:
  - A push is accepted when rpi_push=1 and !queue_full, using the registered full flag.
  - A push while full is dropped even if a pop happens in the same cycle; overflow is set.
  - A push and a pop in the same cycle with count < DEPTH leave count unchanged.
  - Pointers wrap modulo DEPTH.
- flush:
  - Count and pointers go to 0 and overflow clears on the next edge.
  - flush beats a simultaneous push; that push is dropped and does not set overflow.
  - flush does not abort an in-flight task; the FSM continues to completion.
- FSM:
  - S_IDLE: if count>0 and tm_idle=1 and !flush: tm_inst <= FIFO head, pop, go to S_CHECK.
  - S_CHECK (1 cycle, lets tm_inst_valid settle on the stable tm_inst):
    - tm_inst_valid=1: go to S_LAUNCH.
    - else: tasks_rejected++, go to S_IDLE.
  - S_LAUNCH: tm_execute=1 for exactly this cycle; clear the timeout counter; go to S_WAIT_START.
  - S_WAIT_START:
    - tm_idle=0: go to S_WAIT_DONE.
    - else, when the counter reaches START_TIMEOUT-1: tasks_rejected++, go to S_IDLE. This covers valid opcodes that map to no engine.
    - otherwise increment the counter.
  - S_WAIT_DONE: when tm_idle=1: tasks_done++, go to S_IDLE.
    - No timeout here; task_manager enforces its own watchdog and returns to idle.
- tm_inst holds its value from dispatch until the next dispatch; it never changes while tm_execute=1.
- tm_execute is a registered Moore output, asserted only in S_LAUNCH.
- Minimum dispatch-to-dispatch spacing is 5 cycles: IDLE, CHECK, LAUNCH, WAIT_START, WAIT_DONE.

Optional Feature:
- Macro: TASK_SCHED_COUNTERS_EN.
- Defined: tasks_done and tasks_rejected are implemented as specified.
- Undefined: both ports are tied to 16'h0 and no counter flops are synthesized; FSM behaviour is otherwise identical.

Test Plan:
- Reset, push one 80'hFF_000000_000100_000200 with task_manager model idle -> tm_inst equals it 1 cycle after push; tm_execute pulses 1 cycle, 2 cycles later. Model drops idle for 50 cycles -> tasks_done=1, busy=0, queue_count=0.
- Push opcode 8'h10 (tm_inst_valid=0) -> no tm_execute pulse, tasks_rejected=1, FSM back in S_IDLE 2 cycles after dispatch.
- Push opcode 8'hFE with the model never dropping idle -> one tm_execute pulse, tasks_rejected=1 after START_TIMEOUT=16 cycles in S_WAIT_START.
- Push 9 entries back-to-back with tm_idle held low -> first entry waits in the queue; queue_full=1 at count 8; 9th push dropped, overflow=1; then flush -> queue_count=0, overflow=0.
- Flush during S_WAIT_DONE with 3 queued -> in-flight task completes (tasks_done+1), no further dispatch, queue_count=0.
- Assert reset_n low mid-S_WAIT_DONE -> all outputs return to reset values asynchronously, with no tm_execute glitch.
